key_debounce8: RTL and testbench

Eight-channel key conditioning stage that sits directly upstream of the 8-input priority encoder. It takes eight raw mechanical key or switch lines, synchronises them to `clk`, and debounces each one against a shared sample tick. It then presents a clean active-high level vector, which drives the encoder's `IN[7:0]` unchanged. It also produces one-cycle press and release pulses for downstream logic.

---
 rtl/key_pkg.sv | 12 +
 rtl/key_debounce_cell.sv | 53 +++++
 rtl/key_debounce8.sv | 66 ++++++
 tb/tb_key_debounce8.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants and helpers for the key conditioning path
// (debouncer, keypad and encoder wrappers).
package key_pkg;

    localparam int NUM_KEYS = 8;

    // Debounce counter width: enough bits to hold 0..debounce_ticks.
    function automatic int cnt_width(input int debounce_ticks);
        return $clog2(debounce_ticks + 1);
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One debounce channel: accepts a change of the synchronised key only after
// it persists across DEBOUNCE_TICKS consecutive sample ticks.
module key_debounce_cell
    import key_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic k,
    output logic level,
    output logic press,
    output logic rls
);

    localparam int CW = cnt_width(DEBOUNCE_TICKS);

    logic [CW-1:0] c;
    logic [CW-1:0] c_next;
    logic          s_next;

    // Any sample that agrees with the stable state restarts the count.
    always_comb begin
        s_next = level;
        c_next = c;
        if (k == level) begin
            c_next = '0;
        end else if (tick) begin
            if (c == CW'(DEBOUNCE_TICKS - 1)) begin
                s_next = ~level;
                c_next = '0;
            end else begin
                c_next = c + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
            c     <= '0;
            press <= 1'b0;
            rls   <= 1'b0;
        end else begin
            level <= s_next;
            c     <= c_next;
            press <= s_next & ~level;
            rls   <= ~s_next & level;
        end
    end

endmodule

// File: rtl/key_debounce8.sv
// Eight-channel key conditioner: polarity normalisation, 2-FF synchroniser,
// shared sample prescaler and per-key debounce cells feeding the encoder.
module key_debounce8
    import key_pkg::*;
#(
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                tick
);

    localparam int                  DW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [NUM_KEYS-1:0] RAW_IDLE = KEY_ACTIVE_LOW ? '1 : '0;

    logic [NUM_KEYS-1:0] sync_q1;
    logic [NUM_KEYS-1:0] sync_q2;
    logic [NUM_KEYS-1:0] k;
    logic [DW-1:0]       div_cnt;

    // Synchroniser idles at the released raw level so k reads 0 from reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= RAW_IDLE;
            sync_q2 <= RAW_IDLE;
        end else begin
            sync_q1 <= key_in;
            sync_q2 <= sync_q1;
        end
    end

    assign k = KEY_ACTIVE_LOW ? ~sync_q2 : sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DW'(TICK_DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DW'(TICK_DIV - 1));

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_cell
        key_debounce_cell #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .k     (k[i]),
            .level (key_level[i]),
            .press (key_press[i]),
            .rls   (key_release[i])
        );
    end

endmodule

// File: tb/tb_key_debounce8.sv
// Directed + random bench for key_debounce8; a run-length/tick-count model
// predicts level, pulses and tick every cycle.
module tb_key_debounce8;

    localparam int TD = 4;
    localparam int DT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] key_in = 8'h00;
    logic [7:0] key_level, key_press, key_release;
    logic       tick;

    always #5 clk = ~clk;

    key_debounce8 #(
        .TICK_DIV       (TD),
        .DEBOUNCE_TICKS (DT),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .tick        (tick)
    );

    int total = 0;
    int bad   = 0;

    // Model: cycle index since reset release, accepted state, pending pulses,
    // raw history two cycles deep, and start cycle of each key's disagreement run.
    int         t;
    logic [7:0] m_s, m_press, m_rel;
    logic [7:0] h1, h2;
    int         run_start [8];

    function automatic int ticks_in(input int a, input int b);
        return (b + 1) / TD - a / TD;
    endfunction

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic chk_range(input string tag, input int val, input int lo, input int hi);
        total++;
        assert (val >= lo && val <= hi) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d..%0d", tag, val, lo, hi);
        end
    endtask

    task automatic model_reset();
        t = 0; m_s = '0; m_press = '0; m_rel = '0; h1 = '1; h2 = '1;
        for (int i = 0; i < 8; i++) run_start[i] = -1;
    endtask

    // Drive raw for the current cycle, check this cycle, advance one clk.
    task automatic step(input logic [7:0] raw);
        logic [7:0] kk, ns;
        key_in = raw;
        chk8("level", key_level, m_s);
        chk8("press", key_press, m_press);
        chk8("release", key_release, m_rel);
        chk8("tick", {7'b0, tick}, {7'b0, (t % TD) == TD - 1});
        chk8("overlap", key_press & key_release, 8'h00);
        kk = ~h2;
        ns = m_s;
        for (int i = 0; i < 8; i++) begin
            if (kk[i] != m_s[i]) begin
                if (run_start[i] < 0) run_start[i] = t;
                if ((t % TD) == TD - 1 && ticks_in(run_start[i], t) == DT) begin
                    ns[i] = kk[i];
                    run_start[i] = -1;
                end
            end else begin
                run_start[i] = -1;
            end
        end
        m_press = ns & ~m_s;
        m_rel   = ~ns & m_s;
        m_s     = ns;
        h2 = h1;
        h1 = raw;
        t++;
        @(posedge clk); #1;
    endtask

    // Step with constant input until (level & mask) == want or 40 cycles pass.
    task automatic wait_level(input logic [7:0] mask, input logic [7:0] want, input int t0,
                              output int lat);
        while ((key_level & mask) != want && (t - t0) < 40) step(key_in);
        lat = t - t0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, t0, enc;
        logic [7:0] r, seen;

        // Reset with every key held pressed.
        model_reset();
        key_in = 8'h00;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk8("rst_level", key_level, 8'h00);
        chk8("rst_press", key_press, 8'h00);
        chk8("rst_tick", {7'b0, tick}, 8'h00);
        rst_n = 1'b1;
        model_reset();
        repeat (10) step(8'h00);
        wait_level(8'hFF, 8'hFF, 0, lat);
        chk_range("rst_latency", lat, 11, 14);
        chk8("rst_press_pulse", key_press, 8'hFF);
        repeat (20) step(8'hFF);

        // Clean press on key 5, encoder view, pulse width.
        step(8'hDF); t0 = t - 1;
        wait_level(8'hFF, 8'h20, t0, lat);
        chk_range("press_latency", lat, 11, 14);
        chk8("press_pulse", key_press, 8'h20);
        enc = -1;
        for (int i = 0; i < 8; i++) if (key_level[i]) enc = i;
        chk8("encoder", 8'(enc), 8'd5);
        step(8'hDF);
        chk8("press_width", key_press, 8'h00);
        repeat (5) step(8'hDF);

        // Release key 5.
        step(8'hFF); t0 = t - 1;
        wait_level(8'hFF, 8'h00, t0, lat);
        chk_range("release_latency", lat, 11, 14);
        chk8("release_pulse", key_release, 8'h20);
        step(8'hFF);
        chk8("release_width", key_release, 8'h00);
        repeat (5) step(8'hFF);

        // Bounce on key 2: never accepted.
        seen = 8'h00;
        for (int j = 0; j < 40; j++) begin
            r = ((j / 3) % 2 == 0) ? 8'hFB : 8'hFF;
            step(r);
            seen |= key_level | key_press | key_release;
        end
        for (int j = 0; j < 20; j++) begin
            step(8'hFF);
            seen |= key_level | key_press | key_release;
        end
        chk8("bounce_bit2", seen & 8'h04, 8'h00);

        // Keys 7 and 0 together.
        step(8'h7E); t0 = t - 1;
        wait_level(8'hFF, 8'h81, t0, lat);
        chk_range("simul_latency", lat, 11, 14);
        chk8("simul_press", key_press, 8'h81);
        step(8'hFF); t0 = t - 1;
        wait_level(8'hFF, 8'h00, t0, lat);
        chk8("simul_release", key_release, 8'h81);
        repeat (5) step(8'hFF);

        // Reset in the middle of key 3's debounce interval.
        step(8'hF7);
        repeat (7) step(8'hF7);
        rst_n = 1'b0;
        #1;
        chk8("midrst_level0", key_level, 8'h00);
        @(posedge clk); #1;
        chk8("midrst_level1", key_level, 8'h00);
        @(posedge clk); #1;
        chk8("midrst_level2", key_level, 8'h00);
        rst_n = 1'b1;
        model_reset();
        wait_level(8'h08, 8'h08, 0, lat);
        chk_range("midrst_latency", lat, 11, 14);
        chk8("midrst_press", key_press, 8'h08);
        repeat (5) step(8'hF7);

        // Random key activity, including long holds and short glitches.
        r = 8'hFF;
        for (int j = 0; j < 3000; j++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 24) == 0) r[b] = ~r[b];
            step(r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
